nios_core_timer_host: RTL and testbench
=======================================

Name: nios_core_timer_host

Overview:
- Avalon-MM initiator that programs, services and reads back the nios_core interval timer slave on behalf of non-CPU logic (e.g. a DMA sequencer or watchdog supervisor).
- Takes a one-shot or continuous period configuration over a valid/ready handshake, then writes the period and control registers.
- Acknowledges each timeout and counts ticks, using either irq or status polling.
- Services snapshot and stop requests.
- Sits directly on the timer's s1 port; the timer has no waitrequest and a fixed 1-cycle registered read latency.

Parameters:
- DATA_W, 16, Avalon data width (timer register width).
- ADDR_W, 3, Avalon word address width.
- TICK_W, 32, width of tick counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  high in IDLE only
- cfg_period  in  32  timer period in clocks minus one; 0 is clamped to 1
- cfg_continuous  in  1  1 = periodic, 0 = one-shot
- cfg_irq_en  in  1  1 = wait on irq_in, 0 = poll status register
- stop_req  in  1  single-cycle pulse, stop timer
- snap_req  in  1  single-cycle pulse, capture counter snapshot
- snap_valid  out  1  one-cycle pulse, snap_value valid
- snap_value  out  32  captured counter value
- tick_pulse  out  1  one-cycle pulse per acknowledged timeout
- tick_count  out  TICK_W  timeouts since last cfg accept, wraps to 0
- busy  out  1  state != IDLE
- avm_address  out  ADDR_W  word address
- avm_chipselect  out  1
- avm_write_n  out  1  active-low write
- avm_writedata  out  DATA_W
- avm_readdata  in  DATA_W  valid the cycle after address is presented
- irq_in  in  1  timer irq

Behaviour:
- Reset (async, active-high) puts the block in IDLE.
  - avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0.
  - snap_valid=0, snap_value=0, tick_pulse=0, tick_count=0.
  - busy=0, cfg_ready=1.
  - Pending flags cleared.
  - Reset mid-sequence abandons the bus transfer; the timer is not touched again until the next cfg accept.
- Bus output encoding:
  - Moore outputs, registered; one transfer per state cycle, no waitrequest.
  - A write is chipselect=1, write_n=0 for exactly one cycle.
  - A read is chipselect=1, write_n=1; readdata is sampled on the following cycle.
- Register map: 0 status (bit0 TO, bit1 RUN), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 period_l, 3 period_h, 4 snap_l, 5 snap_h.
- Pending flags:
  - stop_req and snap_req set sticky flags in any state; both pulses in the same cycle set both flags.
  - In IDLE a pending stop is discarded; a pending snap is serviced.
- Config:
  - cfg_valid&cfg_ready latches period/continuous/irq_en and clears tick_count.
  - Sequence: WR_PL (addr 2, period[15:0]) -> WR_PH (addr 3, period[31:16]) -> WR_CTRL (addr 1, {0,1,cont,irq_en}) -> RUN.
  - First bus cycle is the cycle after accept; RUN is reached 4 cycles after accept.
- RUN priority each cycle: stop pending > timeout > snap pending. Bus idle in RUN.
- Timeout detection:
  - irq_en=1: irq_in=1 -> CLR_ST.
  - irq_en=0: POLL_RD (read addr 0) -> POLL_CHK. If readdata[0]=1 go to CLR_ST, else back to RUN.
  - While polling, stop or snap pending preempts the next poll, not an in-flight one.
- CLR_ST:
  - Write addr 0, data 0.
  - Next cycle: tick_pulse=1 and tick_count increments (wraps 2^TICK_W-1 -> 0).
  - Then go to RUN if continuous, else IDLE.
  - irq_in is low by the cycle after CLR_ST, so there is no double count.
- Snapshot:
  - SNAP_WR (write addr 4, data 0) -> SNAP_RL (read addr 4) -> SNAP_RH (read addr 5; latch low half) -> SNAP_CAP (bus idle; latch high half).
  - snap_valid pulses with the new snap_value the cycle after SNAP_CAP.
  - Return to the originating state (RUN or IDLE); clear the snap flag on entry to SNAP_WR.
- Stop:
  - STOP_WR (addr 1, data 4'b1000) -> IDLE; clear the stop flag.
  - A pending snap survives and is serviced from IDLE.
- cfg_valid outside IDLE is ignored (cfg_ready=0).

Decomposition:
- Package nios_core_timer_pkg holds:
  - Register offsets (STATUS=0, CONTROL=1, PERIOD_L=2, PERIOD_H=3, SNAP_L=4, SNAP_H=5).
  - Control and status bit indices.
  - State enum: IDLE, WR_PL, WR_PH, WR_CTRL, RUN, POLL_RD, POLL_CHK, CLR_ST, SNAP_WR, SNAP_RL, SNAP_RH, SNAP_CAP, STOP_WR.
- Single module, no sub-module; the FSM, pending flags and tick counter are tightly coupled.

Test Plan:
- Config: period=49999, cont=1, irq_en=1 -> writes, in order, (2,0xC34F), (3,0x0000), (1,0x7); busy=1; RUN 4 cycles after accept.
- Periodic irq: bench timer model, period=9, 3 timeouts -> three CLR_ST writes (0,0x0) exactly 10 clocks apart; tick_count=3; three tick_pulse pulses.
- Polling one-shot: irq_en=0, cont=0, period=5 -> repeated reads of addr 0 until TO=1, one CLR_ST, tick_count=1, back in IDLE with cfg_ready=1.
- Snapshot: model counter=0x0001_2345 -> sequence (4 write), (4 read), (5 read); snap_value=0x00012345; snap_valid for 1 cycle.
- Simultaneous: stop_req and snap_req in the same cycle as irq_in in RUN -> STOP_WR (1,0x8) first, then snapshot from IDLE; no tick counted.
- Reset mid-WR_PH -> next cycle chipselect=0, write_n=1, tick_count=0, cfg_ready=1; period=0 config afterwards writes (2,0x0001).

Source files
------------

// File: rtl/nios_core_timer_pkg.sv
// Register map, bit positions and FSM states shared by the interval-timer host.
package nios_core_timer_pkg;

    // Word offsets of the timer s1 registers
    localparam int unsigned RegStatus  = 0;
    localparam int unsigned RegControl = 1;
    localparam int unsigned RegPeriodL = 2;
    localparam int unsigned RegPeriodH = 3;
    localparam int unsigned RegSnapL   = 4;
    localparam int unsigned RegSnapH   = 5;

    // Status register bits
    localparam int unsigned StatusToBit  = 0;
    localparam int unsigned StatusRunBit = 1;

    // Control register bits
    localparam int unsigned CtrlItoBit   = 0;
    localparam int unsigned CtrlContBit  = 1;
    localparam int unsigned CtrlStartBit = 2;
    localparam int unsigned CtrlStopBit  = 3;

    typedef enum logic [3:0] {
        StIdle,
        StWrPl,
        StWrPh,
        StWrCtrl,
        StRun,
        StPollRd,
        StPollChk,
        StClrSt,
        StSnapWr,
        StSnapRl,
        StSnapRh,
        StSnapCap,
        StStopWr
    } state_e;

    // Assemble the low nibble of a control register write
    function automatic logic [3:0] ctrl_word(input logic cont, input logic ito,
                                             input logic start, input logic stop);
        logic [3:0] w;
        w               = 4'b0000;
        w[CtrlItoBit]   = ito;
        w[CtrlContBit]  = cont;
        w[CtrlStartBit] = start;
        w[CtrlStopBit]  = stop;
        return w;
    endfunction

endpackage

// File: rtl/nios_core_timer_host_if.sv
// Avalon-MM link between the timer host (master) and the timer s1 port (slave).
interface nios_core_timer_host_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write_n;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;
    logic              irq_in;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_write_n,
        output avm_writedata,
        input  avm_readdata,
        input  irq_in
    );

    modport slave (
        input  avm_address,
        input  avm_chipselect,
        input  avm_write_n,
        input  avm_writedata,
        output avm_readdata,
        output irq_in
    );
endinterface

// File: rtl/nios_core_timer_host.sv
// Programs the interval timer, acknowledges timeouts (irq or polling), counts
// ticks and services snapshot/stop requests. Bus outputs are decoded from the
// next state and registered, so each transfer lines up with its state cycle.
// Register halves assume DATA_W = 16.
module nios_core_timer_host
    import nios_core_timer_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned TICK_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_continuous,
    input  logic              cfg_irq_en,
    input  logic              stop_req,
    input  logic              snap_req,
    output logic              snap_valid,
    output logic [31:0]       snap_value,
    output logic              tick_pulse,
    output logic [TICK_W-1:0] tick_count,
    output logic              busy,
    nios_core_timer_host_if.master avm
);

    state_e            state_q, state_d;
    logic              ret_run_q, ret_run_d;
    logic [31:0]       period_q, period_d;
    logic              cont_q, cont_d;
    logic              irq_en_q, irq_en_d;
    logic              stop_pend_q, stop_pend_d;
    logic              snap_pend_q, snap_pend_d;
    logic [15:0]       snap_lo_q, snap_lo_d;
    logic [31:0]       snap_value_q, snap_value_d;
    logic              snap_valid_q, snap_valid_d;
    logic              tick_pulse_q, tick_pulse_d;
    logic [TICK_W-1:0] tick_count_q, tick_count_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cs_q, cs_d;
    logic              wr_n_q, wr_n_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // Requests arriving this cycle count as already pending
    logic stop_pend_w, snap_pend_w;

    // Next-state, pending-flag, tick and snapshot logic
    always_comb begin
        state_d      = state_q;
        ret_run_d    = ret_run_q;
        period_d     = period_q;
        cont_d       = cont_q;
        irq_en_d     = irq_en_q;
        snap_lo_d    = snap_lo_q;
        snap_value_d = snap_value_q;
        snap_valid_d = 1'b0;
        tick_pulse_d = 1'b0;
        tick_count_d = tick_count_q;
        stop_pend_w  = stop_pend_q | stop_req;
        snap_pend_w  = snap_pend_q | snap_req;
        stop_pend_d  = stop_pend_w;
        snap_pend_d  = snap_pend_w;

        case (state_q)
            StIdle: begin
                // Nothing to stop while idle
                stop_pend_d = 1'b0;
                if (cfg_valid) begin
                    period_d     = (cfg_period == 32'd0) ? 32'd1 : cfg_period;
                    cont_d       = cfg_continuous;
                    irq_en_d     = cfg_irq_en;
                    tick_count_d = '0;
                    state_d      = StWrPl;
                end else if (snap_pend_w) begin
                    snap_pend_d = 1'b0;
                    ret_run_d   = 1'b0;
                    state_d     = StSnapWr;
                end
            end
            StWrPl:   state_d = StWrPh;
            StWrPh:   state_d = StWrCtrl;
            StWrCtrl: state_d = StRun;
            StRun: begin
                if (stop_pend_w) begin
                    stop_pend_d = 1'b0;
                    state_d     = StStopWr;
                end else if (irq_en_q && avm.irq_in) begin
                    state_d = StClrSt;
                end else if (snap_pend_w) begin
                    snap_pend_d = 1'b0;
                    ret_run_d   = 1'b1;
                    state_d     = StSnapWr;
                end else if (!irq_en_q) begin
                    state_d = StPollRd;
                end
            end
            StPollRd:  state_d = StPollChk;
            StPollChk: state_d = avm.avm_readdata[StatusToBit] ? StClrSt : StRun;
            StClrSt: begin
                tick_pulse_d = 1'b1;
                tick_count_d = tick_count_q + TICK_W'(1);
                state_d      = cont_q ? StRun : StIdle;
            end
            StSnapWr: state_d = StSnapRl;
            StSnapRl: state_d = StSnapRh;
            StSnapRh: begin
                snap_lo_d = avm.avm_readdata[15:0];
                state_d   = StSnapCap;
            end
            StSnapCap: begin
                snap_value_d = {avm.avm_readdata[15:0], snap_lo_q};
                snap_valid_d = 1'b1;
                state_d      = ret_run_q ? StRun : StIdle;
            end
            StStopWr: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Moore bus decode of the state being entered
    always_comb begin
        cs_d        = 1'b0;
        wr_n_d      = 1'b1;
        addr_d      = '0;
        wdata_d     = '0;
        cfg_ready_d = (state_d == StIdle);
        busy_d      = (state_d != StIdle);
        unique case (state_d)
            StWrPl: begin
                cs_d    = 1'b1;
                wr_n_d  = 1'b0;
                addr_d  = ADDR_W'(RegPeriodL);
                wdata_d = DATA_W'(period_d[15:0]);
            end
            StWrPh: begin
                cs_d    = 1'b1;
                wr_n_d  = 1'b0;
                addr_d  = ADDR_W'(RegPeriodH);
                wdata_d = DATA_W'(period_d[31:16]);
            end
            StWrCtrl: begin
                cs_d    = 1'b1;
                wr_n_d  = 1'b0;
                addr_d  = ADDR_W'(RegControl);
                wdata_d = DATA_W'(ctrl_word(cont_d, irq_en_d, 1'b1, 1'b0));
            end
            StPollRd: begin
                cs_d   = 1'b1;
                addr_d = ADDR_W'(RegStatus);
            end
            StClrSt: begin
                cs_d   = 1'b1;
                wr_n_d = 1'b0;
                addr_d = ADDR_W'(RegStatus);
            end
            StSnapWr: begin
                cs_d   = 1'b1;
                wr_n_d = 1'b0;
                addr_d = ADDR_W'(RegSnapL);
            end
            StSnapRl: begin
                cs_d   = 1'b1;
                addr_d = ADDR_W'(RegSnapL);
            end
            StSnapRh: begin
                cs_d   = 1'b1;
                addr_d = ADDR_W'(RegSnapH);
            end
            StStopWr: begin
                cs_d    = 1'b1;
                wr_n_d  = 1'b0;
                addr_d  = ADDR_W'(RegControl);
                wdata_d = DATA_W'(ctrl_word(1'b0, 1'b0, 1'b0, 1'b1));
            end
            default: ;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            ret_run_q    <= 1'b0;
            period_q     <= '0;
            cont_q       <= 1'b0;
            irq_en_q     <= 1'b0;
            stop_pend_q  <= 1'b0;
            snap_pend_q  <= 1'b0;
            snap_lo_q    <= '0;
            snap_value_q <= '0;
            snap_valid_q <= 1'b0;
            tick_pulse_q <= 1'b0;
            tick_count_q <= '0;
            cfg_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            addr_q       <= '0;
            cs_q         <= 1'b0;
            wr_n_q       <= 1'b1;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            ret_run_q    <= ret_run_d;
            period_q     <= period_d;
            cont_q       <= cont_d;
            irq_en_q     <= irq_en_d;
            stop_pend_q  <= stop_pend_d;
            snap_pend_q  <= snap_pend_d;
            snap_lo_q    <= snap_lo_d;
            snap_value_q <= snap_value_d;
            snap_valid_q <= snap_valid_d;
            tick_pulse_q <= tick_pulse_d;
            tick_count_q <= tick_count_d;
            cfg_ready_q  <= cfg_ready_d;
            busy_q       <= busy_d;
            addr_q       <= addr_d;
            cs_q         <= cs_d;
            wr_n_q       <= wr_n_d;
            wdata_q      <= wdata_d;
        end
    end

    assign cfg_ready          = cfg_ready_q;
    assign busy               = busy_q;
    assign snap_valid         = snap_valid_q;
    assign snap_value         = snap_value_q;
    assign tick_pulse         = tick_pulse_q;
    assign tick_count         = tick_count_q;
    assign avm.avm_address    = addr_q;
    assign avm.avm_chipselect = cs_q;
    assign avm.avm_write_n    = wr_n_q;
    assign avm.avm_writedata  = wdata_q;

endmodule

// File: tb/tb_nios_core_timer_host.sv
// Bench for the timer host: a behavioural interval timer answers on the bus,
// and a scoreboard of expected transfers is checked as the host issues them.
module tb_nios_core_timer_host;
    import nios_core_timer_pkg::*;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned TICK_W = 32;

    typedef struct packed {
        logic [2:0]  addr;
        logic        wr;
        logic [15:0] data;
        logic        rep;   // read that may repeat (status polling)
    } xfer_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [31:0]       cfg_period = '0;
    logic              cfg_continuous = 1'b0;
    logic              cfg_irq_en = 1'b0;
    logic              stop_req = 1'b0;
    logic              snap_req = 1'b0;
    logic              snap_valid;
    logic [31:0]       snap_value;
    logic              tick_pulse;
    logic [TICK_W-1:0] tick_count;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_tick_seen = 0;
    int n_snap_seen = 0;
    int n_poll_rd   = 0;
    int unsigned clr_cyc[$];
    int unsigned cyc = 0;
    xfer_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nios_core_timer_host_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) avm ();

    nios_core_timer_host #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TICK_W(TICK_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_period     (cfg_period),
        .cfg_continuous (cfg_continuous),
        .cfg_irq_en     (cfg_irq_en),
        .stop_req       (stop_req),
        .snap_req       (snap_req),
        .snap_valid     (snap_valid),
        .snap_value     (snap_value),
        .tick_pulse     (tick_pulse),
        .tick_count     (tick_count),
        .busy           (busy),
        .avm            (avm)
    );

    // Behavioural interval timer: counts down from period, TO set on reaching 0
    logic [31:0] m_period = '0, m_cnt = '0, m_snap = '0, m_load_val = '0;
    logic m_ito = 1'b0, m_cont = 1'b0, m_run = 1'b0, m_to = 1'b0;
    logic m_clear = 1'b1, m_load = 1'b0, irq_force = 1'b0;

    assign avm.irq_in = (m_to & m_ito) | irq_force;

    always @(posedge clk) begin
        if (m_clear) begin
            m_period <= '0; m_cnt <= '0; m_snap <= '0;
            m_ito <= 1'b0; m_cont <= 1'b0; m_run <= 1'b0; m_to <= 1'b0;
            avm.avm_readdata <= '0;
        end else begin
            if (m_load) m_cnt <= m_load_val;
            else if (m_run) begin
                if (m_cnt == 32'd0) begin
                    m_to <= 1'b1;
                    if (m_cont) m_cnt <= m_period;
                    else m_run <= 1'b0;
                end else m_cnt <= m_cnt - 32'd1;
            end
            if (avm.avm_chipselect && !avm.avm_write_n) begin
                case (avm.avm_address)
                    3'd0: m_to <= 1'b0;
                    3'd1: begin
                        m_ito  <= avm.avm_writedata[CtrlItoBit];
                        m_cont <= avm.avm_writedata[CtrlContBit];
                        if (avm.avm_writedata[CtrlStartBit]) begin
                            m_run <= 1'b1;
                            m_cnt <= m_period;
                        end
                        if (avm.avm_writedata[CtrlStopBit]) m_run <= 1'b0;
                    end
                    3'd2: m_period[15:0]  <= avm.avm_writedata;
                    3'd3: m_period[31:16] <= avm.avm_writedata;
                    3'd4, 3'd5: m_snap <= m_cnt;
                    default: ;
                endcase
            end
            avm.avm_readdata <= '0;
            if (avm.avm_chipselect && avm.avm_write_n) begin
                case (avm.avm_address)
                    3'd0: begin
                        avm.avm_readdata[StatusToBit]  <= m_to;
                        avm.avm_readdata[StatusRunBit] <= m_run;
                    end
                    3'd4: avm.avm_readdata <= m_snap[15:0];
                    3'd5: avm.avm_readdata <= m_snap[31:16];
                    default: ;
                endcase
            end
        end
    end

    // Scoreboard: every bus transfer is popped from exp_q and compared
    task automatic run_monitor();
        xfer_t e;
        logic  wr;
        forever begin
            @(negedge clk);
            if (tick_pulse) n_tick_seen++;
            if (snap_valid) n_snap_seen++;
            if (avm.avm_chipselect && !reset) begin
                wr = !avm.avm_write_n;
                if (wr && avm.avm_address == 3'd0) clr_cyc.push_back(cyc);
                if (!wr && avm.avm_address == 3'd0) n_poll_rd++;
                if (exp_q.size() > 0 && exp_q[0].rep &&
                    (exp_q[0].addr != avm.avm_address || exp_q[0].wr != wr))
                    void'(exp_q.pop_front());
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL xfer_unexpected: got addr=%0d wr=%0b data=0x%04h, required none",
                             avm.avm_address, wr, avm.avm_writedata);
                end else begin
                    e = exp_q[0];
                    if (e.addr !== avm.avm_address || e.wr !== wr ||
                        (e.wr && e.data !== avm.avm_writedata)) begin
                        n_fail++;
                        $display("FAIL xfer_order: got addr=%0d wr=%0b data=0x%04h, required addr=%0d wr=%0b data=0x%04h",
                                 avm.avm_address, wr, avm.avm_writedata, e.addr, e.wr, e.data);
                    end
                    if (!e.rep) void'(exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic push_exp(input logic [2:0] a, input logic w, input logic [15:0] d,
                            input logic r);
        exp_q.push_back('{addr: a, wr: w, data: d, rep: r});
    endtask

    task automatic do_reset();
        reset = 1'b1; m_clear = 1'b1; cfg_valid = 1'b0; stop_req = 1'b0;
        snap_req = 1'b0; irq_force = 1'b0; m_load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; m_clear = 1'b0;
        exp_q.delete(); clr_cyc.delete();
        n_tick_seen = 0; n_snap_seen = 0; n_poll_rd = 0;
    endtask

    task automatic drive_cfg(input logic [31:0] p, input logic c, input logic ie);
        @(posedge clk); #1;
        cfg_period = p; cfg_continuous = c; cfg_irq_en = ie; cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %0b, required 1", cfg_ready); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b, required 0", busy); end
        n_tests++; if (avm.avm_chipselect !== 1'b0) begin n_fail++; $display("FAIL reset_cs: got %0b, required 0", avm.avm_chipselect); end
        n_tests++; if (avm.avm_write_n !== 1'b1) begin n_fail++; $display("FAIL reset_write_n: got %0b, required 1", avm.avm_write_n); end
        n_tests++; if (avm.avm_address !== 3'd0) begin n_fail++; $display("FAIL reset_addr: got %0d, required 0", avm.avm_address); end
        n_tests++; if (avm.avm_writedata !== 16'd0) begin n_fail++; $display("FAIL reset_wdata: got 0x%0h, required 0", avm.avm_writedata); end
        n_tests++; if (tick_count !== '0 || tick_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got cnt=%0d pulse=%0b, required 0/0", tick_count, tick_pulse); end
        n_tests++; if (snap_valid !== 1'b0 || snap_value !== 32'd0) begin n_fail++; $display("FAIL reset_snap: got v=%0b val=0x%0h, required 0/0", snap_valid, snap_value); end
    endtask

    task automatic test_config();
        do_reset();
        push_exp(3'd2, 1'b1, 16'hC34F, 1'b0);
        push_exp(3'd3, 1'b1, 16'h0000, 1'b0);
        push_exp(3'd1, 1'b1, 16'h0007, 1'b0);
        drive_cfg(32'd49999, 1'b1, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_tests++;
            if (avm.avm_chipselect !== logic'(k <= 3)) begin
                n_fail++;
                $display("FAIL config_cs_cycle%0d: got %0b, required %0b", k, avm.avm_chipselect, k <= 3);
            end
        end
        n_tests++; if (busy !== 1'b1 || cfg_ready !== 1'b0) begin n_fail++; $display("FAIL config_busy: got busy=%0b ready=%0b, required 1/0", busy, cfg_ready); end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL config_pending: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_periodic_irq();
        do_reset();
        push_exp(3'd2, 1'b1, 16'd9, 1'b0);
        push_exp(3'd3, 1'b1, 16'd0, 1'b0);
        push_exp(3'd1, 1'b1, 16'h0007, 1'b0);
        repeat (3) push_exp(3'd0, 1'b1, 16'd0, 1'b0);
        drive_cfg(32'd9, 1'b1, 1'b1);
        for (int i = 0; i < 200 && tick_count != 3; i++) @(negedge clk);
        @(negedge clk);
        n_tests++; if (tick_count !== 32'd3) begin n_fail++; $display("FAIL irq_tick_count: got %0d, required 3", tick_count); end
        n_tests++; if (n_tick_seen != 3) begin n_fail++; $display("FAIL irq_tick_pulses: got %0d, required 3", n_tick_seen); end
        n_tests++;
        if (clr_cyc.size() != 3) begin
            n_fail++; $display("FAIL irq_clr_count: got %0d, required 3", clr_cyc.size());
        end else begin
            if (clr_cyc[1] - clr_cyc[0] != 10 || clr_cyc[2] - clr_cyc[1] != 10) begin
                n_fail++;
                $display("FAIL irq_clr_spacing: got %0d,%0d, required 10,10",
                         clr_cyc[1] - clr_cyc[0], clr_cyc[2] - clr_cyc[1]);
            end
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL irq_pending: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_poll_oneshot();
        do_reset();
        push_exp(3'd2, 1'b1, 16'd5, 1'b0);
        push_exp(3'd3, 1'b1, 16'd0, 1'b0);
        push_exp(3'd1, 1'b1, 16'h0004, 1'b0);
        push_exp(3'd0, 1'b0, 16'd0, 1'b1);
        push_exp(3'd0, 1'b1, 16'd0, 1'b0);
        drive_cfg(32'd5, 1'b0, 1'b0);
        for (int i = 0; i < 200 && (busy || tick_count != 1); i++) @(negedge clk);
        repeat (5) @(negedge clk);
        n_tests++; if (tick_count !== 32'd1) begin n_fail++; $display("FAIL poll_tick_count: got %0d, required 1", tick_count); end
        n_tests++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL poll_idle: got busy=%0b ready=%0b, required 0/1", busy, cfg_ready); end
        n_tests++; if (n_tick_seen != 1) begin n_fail++; $display("FAIL poll_tick_pulses: got %0d, required 1", n_tick_seen); end
        n_tests++; if (n_poll_rd < 2) begin n_fail++; $display("FAIL poll_reads: got %0d, required >=2", n_poll_rd); end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL poll_pending: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_snapshot();
        do_reset();
        @(posedge clk); #1;
        m_load = 1'b1; m_load_val = 32'h0001_2345;
        @(posedge clk); #1;
        m_load = 1'b0;
        push_exp(3'd4, 1'b1, 16'd0, 1'b0);
        push_exp(3'd4, 1'b0, 16'd0, 1'b0);
        push_exp(3'd5, 1'b0, 16'd0, 1'b0);
        snap_req = 1'b1;
        @(posedge clk); #1;
        snap_req = 1'b0;
        for (int i = 0; i < 20 && !snap_valid; i++) @(negedge clk);
        n_tests++; if (snap_valid !== 1'b1) begin n_fail++; $display("FAIL snap_valid: got %0b, required 1", snap_valid); end
        n_tests++; if (snap_value !== 32'h0001_2345) begin n_fail++; $display("FAIL snap_value: got 0x%08h, required 0x00012345", snap_value); end
        @(negedge clk);
        n_tests++; if (snap_valid !== 1'b0) begin n_fail++; $display("FAIL snap_pulse_width: got %0b, required 0", snap_valid); end
        n_tests++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL snap_idle: got busy=%0b ready=%0b, required 0/1", busy, cfg_ready); end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL snap_pending: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        push_exp(3'd2, 1'b1, 16'd1000, 1'b0);
        push_exp(3'd3, 1'b1, 16'd0, 1'b0);
        push_exp(3'd1, 1'b1, 16'h0007, 1'b0);
        drive_cfg(32'd1000, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        push_exp(3'd1, 1'b1, 16'h0008, 1'b0);
        push_exp(3'd4, 1'b1, 16'd0, 1'b0);
        push_exp(3'd4, 1'b0, 16'd0, 1'b0);
        push_exp(3'd5, 1'b0, 16'd0, 1'b0);
        @(posedge clk); #1;
        stop_req = 1'b1; snap_req = 1'b1; irq_force = 1'b1;
        @(posedge clk); #1;
        stop_req = 1'b0; snap_req = 1'b0; irq_force = 1'b0;
        for (int i = 0; i < 30 && !snap_valid; i++) @(negedge clk);
        n_tests++; if (snap_valid !== 1'b1 || snap_value !== m_snap) begin n_fail++; $display("FAIL simul_snap: got v=%0b val=0x%08h, required 1/0x%08h", snap_valid, snap_value, m_snap); end
        repeat (3) @(negedge clk);
        n_tests++; if (tick_count !== '0 || n_tick_seen != 0) begin n_fail++; $display("FAIL simul_no_tick: got cnt=%0d pulses=%0d, required 0/0", tick_count, n_tick_seen); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL simul_idle: got busy=%0b, required 0", busy); end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL simul_pending: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_exp(3'd2, 1'b1, 16'h5678, 1'b0);
        push_exp(3'd3, 1'b1, 16'h1234, 1'b0);
        drive_cfg(32'h1234_5678, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1; m_clear = 1'b1;
        #1;
        n_tests++; if (avm.avm_chipselect !== 1'b0 || avm.avm_write_n !== 1'b1) begin n_fail++; $display("FAIL rstmid_async_bus: got cs=%0b wn=%0b, required 0/1", avm.avm_chipselect, avm.avm_write_n); end
        @(posedge clk); #1;
        reset = 1'b0; m_clear = 1'b0;
        @(negedge clk);
        n_tests++; if (avm.avm_chipselect !== 1'b0 || avm.avm_write_n !== 1'b1) begin n_fail++; $display("FAIL rstmid_bus: got cs=%0b wn=%0b, required 0/1", avm.avm_chipselect, avm.avm_write_n); end
        n_tests++; if (tick_count !== '0 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_state: got cnt=%0d ready=%0b, required 0/1", tick_count, cfg_ready); end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rstmid_pending: got %0d left, required 0", exp_q.size()); end
        // Period 0 is clamped to 1
        push_exp(3'd2, 1'b1, 16'd1, 1'b0);
        push_exp(3'd3, 1'b1, 16'd0, 1'b0);
        push_exp(3'd1, 1'b1, 16'h0005, 1'b0);
        push_exp(3'd0, 1'b1, 16'd0, 1'b0);
        drive_cfg(32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 50 && (busy || tick_count != 1); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_tests++; if (tick_count !== 32'd1) begin n_fail++; $display("FAIL clamp_tick_count: got %0d, required 1", tick_count); end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL clamp_pending: got %0d left, required 0", exp_q.size()); end
    endtask

    initial begin
        fork
            run_monitor();
        join_none
        test_reset();
        test_config();
        test_periodic_irq();
        test_poll_oneshot();
        test_snapshot();
        test_simultaneous();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
